eth_phy_mgr: RTL and testbench

- Upstream sequencer for the eth_mdio engine; sole driver of its usr_* command interface.
- After reset, it writes a parameterised PHY init table, then polls BMSR (reg 0x01) periodically to track link state.
- It also arbitrates one-off host register accesses into the same engine.

---
 rtl/eth_phy_mgr.sv | 174 +++++++++++++++++
 tb/tb_eth_phy_mgr.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_phy_mgr.sv
// PHY management sequencer: runs a PHY init table after reset, then polls BMSR
// for link state and arbitrates host register accesses into the MDIO engine.
module eth_phy_mgr #(
  parameter logic [4:0]   G_PHY_ADDR    = 5'h06,
  parameter int unsigned  G_RST_WAIT    = 1000,
  parameter int unsigned  G_INIT_NUM    = 2,
  parameter logic [167:0] G_INIT_TBL    = '0,
  parameter int unsigned  G_POLL_PERIOD = 100000,
  parameter int unsigned  G_TMO         = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic        host_dir,
  input  logic [4:0]  host_areg,
  input  logic [15:0] host_txd,
  output logic        host_ack,
  output logic [15:0] host_rxd,
  output logic        mdio_start,
  output logic        mdio_dir,
  output logic [4:0]  mdio_aphy,
  output logic [4:0]  mdio_areg,
  output logic [15:0] mdio_txd,
  input  logic [15:0] mdio_rxd,
  input  logic        mdio_done,
  input  logic        mdio_busy,
  output logic        init_done,
  output logic        link_up,
  output logic        link_chg,
  output logic        err_tmo
);

  typedef enum logic [2:0] {S_WAIT, S_INIT, S_IDLE, S_ISSUE, S_RUN} state_t;
  typedef enum logic [1:0] {K_INIT, K_POLL, K_HOST} kind_t;

  localparam logic [31:0] WAIT_N    = 32'(G_RST_WAIT);
  localparam logic [31:0] POLL_LAST = 32'(G_POLL_PERIOD - 1);
  localparam logic [31:0] TMO_LAST  = 32'(G_TMO - 1);
  localparam logic [3:0]  INIT_N    = 4'(G_INIT_NUM);

  state_t      state;
  kind_t       kind;
  logic [31:0] wait_cnt;
  logic [31:0] poll_cnt;
  logic [31:0] tmo_cnt;
  logic [3:0]  idx;
  logic        poll_pend;
  logic        poll_tick;
  logic        link_prev;
  logic [20:0] entry;

  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (idx == 4'(i)) entry = G_INIT_TBL[21*i +: 21];
  end

  assign poll_tick = init_done && (poll_cnt == POLL_LAST);
  assign mdio_aphy = G_PHY_ADDR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) poll_cnt <= '0;
    else if (init_done) poll_cnt <= poll_tick ? '0 : poll_cnt + 32'd1;
  end

  // link_chg fires the cycle after link_up takes a new value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_prev <= 1'b0;
      link_chg  <= 1'b0;
    end else begin
      link_prev <= link_up;
      link_chg  <= link_up ^ link_prev;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_WAIT;
      kind       <= K_INIT;
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      idx        <= '0;
      poll_pend  <= 1'b0;
      mdio_start <= 1'b0;
      mdio_dir   <= 1'b0;
      mdio_areg  <= '0;
      mdio_txd   <= '0;
      host_ack   <= 1'b0;
      host_rxd   <= '0;
      init_done  <= 1'b0;
      link_up    <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      mdio_start <= 1'b0;
      host_ack   <= 1'b0;
      // a tick during a busy transaction is kept; repeated ticks merge
      if (poll_tick) poll_pend <= 1'b1;
      case (state)
        S_WAIT: begin
          if (wait_cnt + 32'd1 >= WAIT_N) begin
            if (INIT_N == '0) begin
              init_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_INIT;
            end
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_INIT: begin
          kind      <= K_INIT;
          mdio_dir  <= 1'b1;
          mdio_areg <= entry[20:16];
          mdio_txd  <= entry[15:0];
          state     <= S_ISSUE;
        end
        S_IDLE: begin
          if (host_req) begin
            kind      <= K_HOST;
            mdio_dir  <= host_dir;
            mdio_areg <= host_areg;
            mdio_txd  <= host_txd;
            state     <= S_ISSUE;
          end else if (poll_pend || poll_tick) begin
            kind      <= K_POLL;
            mdio_dir  <= 1'b0;
            mdio_areg <= 5'h01;
            mdio_txd  <= '0;
            poll_pend <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!mdio_busy) begin
            mdio_start <= 1'b1;
            tmo_cnt    <= '0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (mdio_done || tmo_cnt == TMO_LAST) begin
            if (!mdio_done) err_tmo <= 1'b1;
            case (kind)
              K_POLL: begin
                if (mdio_done) link_up <= mdio_rxd[2];
                state <= S_IDLE;
              end
              K_HOST: begin
                host_ack <= 1'b1;
                if (!mdio_dir) host_rxd <= mdio_done ? mdio_rxd : 16'hFFFF;
                state <= S_IDLE;
              end
              default: begin
                idx <= idx + 4'd1;
                if (idx + 4'd1 == INIT_N) begin
                  init_done <= 1'b1;
                  state     <= S_IDLE;
                end else begin
                  state <= S_INIT;
                end
              end
            endcase
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_phy_mgr.sv
// Scoreboard bench for eth_phy_mgr with a behavioural MDIO engine responder.
module tb_eth_phy_mgr;

  localparam int W   = 20;
  localparam int P   = 200;
  localparam int TMO = 50;
  localparam logic [167:0] TBL = {126'b0, 5'h04, 16'h01E1, 5'h00, 16'h8000};

  typedef struct packed {
    logic        dir;
    logic [4:0]  areg;
    logic [15:0] txd;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_req = 1'b0;
  logic        host_dir = 1'b0;
  logic [4:0]  host_areg = '0;
  logic [15:0] host_txd = '0;
  logic        host_ack;
  logic [15:0] host_rxd;
  logic        mdio_start;
  logic        mdio_dir;
  logic [4:0]  mdio_aphy;
  logic [4:0]  mdio_areg;
  logic [15:0] mdio_txd;
  logic [15:0] mdio_rxd = '0;
  logic        mdio_done = 1'b0;
  logic        mdio_busy = 1'b0;
  logic        init_done;
  logic        link_up;
  logic        link_chg;
  logic        err_tmo;

  int errors = 0;
  int checks = 0;
  int n_start = 0;

  txn_t        exp_txn[$];
  logic [15:0] exp_host[$];
  logic        exp_link[$];

  logic [15:0] poll_rxd = 16'h0000;
  logic [15:0] host_rd_val = 16'h0000;
  logic        no_done = 1'b0;

  eth_phy_mgr #(
    .G_PHY_ADDR   (5'h06),
    .G_RST_WAIT   (W),
    .G_INIT_NUM   (2),
    .G_INIT_TBL   (TBL),
    .G_POLL_PERIOD(P),
    .G_TMO        (TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_dir(host_dir), .host_areg(host_areg), .host_txd(host_txd),
    .host_ack(host_ack), .host_rxd(host_rxd),
    .mdio_start(mdio_start), .mdio_dir(mdio_dir), .mdio_aphy(mdio_aphy),
    .mdio_areg(mdio_areg), .mdio_txd(mdio_txd), .mdio_rxd(mdio_rxd),
    .mdio_done(mdio_done), .mdio_busy(mdio_busy),
    .init_done(init_done), .link_up(link_up), .link_chg(link_chg), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return mdio_start;
      1: return host_ack;
      2: return link_chg;
      default: return init_done;
    endcase
  endfunction

  task automatic wait_for(input int s, input int budget, input string name, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!sig(s) && cyc < budget);
    if (!sig(s)) begin
      checks++;
      errors++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_host_ack"},  32'(host_ack),   32'h0);
    check({tag, "_host_rxd"},  32'(host_rxd),   32'h0);
    check({tag, "_start"},     32'(mdio_start), 32'h0);
    check({tag, "_dir"},       32'(mdio_dir),   32'h0);
    check({tag, "_aphy"},      32'(mdio_aphy),  32'h06);
    check({tag, "_areg"},      32'(mdio_areg),  32'h0);
    check({tag, "_txd"},       32'(mdio_txd),   32'h0);
    check({tag, "_init_done"}, 32'(init_done),  32'h0);
    check({tag, "_link_up"},   32'(link_up),    32'h0);
    check({tag, "_link_chg"},  32'(link_chg),   32'h0);
    check({tag, "_err_tmo"},   32'(err_tmo),    32'h0);
  endtask

  // Engine responder: busy for 4 cycles after start, then done (unless suppressed)
  initial begin
    logic       e_dir;
    logic [4:0] e_areg;
    forever begin
      @(posedge clk); #1;
      if (mdio_start) begin
        e_dir = mdio_dir;
        e_areg = mdio_areg;
        mdio_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (!no_done) begin
          mdio_rxd = e_dir ? 16'h0000 : ((e_areg == 5'h01) ? poll_rxd : host_rd_val);
          mdio_done = 1'b1;
          @(posedge clk); #1;
          mdio_done = 1'b0;
        end
        mdio_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && mdio_start) begin
      txn_t t;
      n_start++;
      check("txn_aphy", 32'(mdio_aphy), 32'h06);
      if (exp_txn.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL txn_unexpected: got dir=%0d areg=0x%0h expected none", mdio_dir, mdio_areg);
      end else begin
        t = exp_txn.pop_front();
        check("txn_dir", 32'(mdio_dir), 32'(t.dir));
        check("txn_areg", 32'(mdio_areg), 32'(t.areg));
        if (t.dir) check("txn_txd", 32'(mdio_txd), 32'(t.txd));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && host_ack) begin
      if (exp_host.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL host_ack_unexpected: got ack expected none");
      end else begin
        check("host_rxd", 32'(host_rxd), 32'(exp_host.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && link_chg) begin
      if (exp_link.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL link_chg_unexpected: got pulse link_up=%0d expected none", link_up);
      end else begin
        check("link_up", 32'(link_up), 32'(exp_link.pop_front()));
      end
    end
  end

  initial begin
    int cyc;
    int base;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");

    // Init table then first poll
    exp_txn.push_back('{dir: 1'b1, areg: 5'h00, txd: 16'h8000});
    exp_txn.push_back('{dir: 1'b1, areg: 5'h04, txd: 16'h01E1});
    exp_txn.push_back('{dir: 1'b0, areg: 5'h01, txd: 16'h0000});
    exp_link.push_back(1'b1);
    poll_rxd = 16'h796D;
    rst = 1'b1;
    wait_for(0, W + 10, "first_start", cyc);
    check("rst_wait_window", 32'(cyc >= W + 1 && cyc <= W + 3), 32'h1);
    check("init_done_early", 32'(init_done), 32'h0);
    wait_for(3, 40, "init_done", cyc);
    check("init_starts", 32'(n_start), 32'd2);

    wait_for(2, P + 40, "link_up_rise", cyc);

    // Second poll drops the link
    poll_rxd = 16'h7969;
    exp_txn.push_back('{dir: 1'b0, areg: 5'h01, txd: 16'h0000});
    exp_link.push_back(1'b0);
    wait_for(2, P + 40, "link_up_fall", cyc);

    // Host read while idle
    host_rd_val = 16'h0141;
    exp_txn.push_back('{dir: 1'b0, areg: 5'h02, txd: 16'h0000});
    exp_host.push_back(16'h0141);
    host_dir = 1'b0; host_areg = 5'h02; host_req = 1'b1;
    wait_for(0, 10, "host_rd_start", cyc);
    check("host_latency", 32'(cyc), 32'd2);
    wait_for(1, 20, "host_rd_ack", cyc);
    host_req = 1'b0;

    // Host write, request dropped right after start; read data must stay held
    exp_txn.push_back('{dir: 1'b1, areg: 5'h00, txd: 16'h1234});
    exp_host.push_back(16'h0141);
    host_dir = 1'b1; host_areg = 5'h00; host_txd = 16'h1234; host_req = 1'b1;
    wait_for(0, 10, "host_wr_start", cyc);
    host_req = 1'b0;
    wait_for(1, 20, "host_wr_ack", cyc);

    // Host request lands on the same edge as the next poll tick
    exp_txn.push_back('{dir: 1'b0, areg: 5'h01, txd: 16'h0000});
    wait_for(0, P + 20, "poll3_start", cyc);
    host_rd_val = 16'hBEEF;
    exp_txn.push_back('{dir: 1'b0, areg: 5'h03, txd: 16'h0000});
    exp_txn.push_back('{dir: 1'b0, areg: 5'h01, txd: 16'h0000});
    exp_host.push_back(16'hBEEF);
    repeat (P - 2) @(posedge clk);
    #1;
    host_dir = 1'b0; host_areg = 5'h03; host_req = 1'b1;
    wait_for(0, 10, "coll_host_start", cyc);
    check("coll_host_latency", 32'(cyc), 32'd2);
    wait_for(1, 20, "coll_host_ack", cyc);
    host_req = 1'b0;
    wait_for(0, 10, "coll_poll_start", cyc);
    check("pending_poll_latency", 32'(cyc), 32'd2);
    repeat (8) @(posedge clk);
    #1;

    // Host read with no done from the engine
    no_done = 1'b1;
    exp_txn.push_back('{dir: 1'b0, areg: 5'h05, txd: 16'h0000});
    exp_host.push_back(16'hFFFF);
    host_dir = 1'b0; host_areg = 5'h05; host_req = 1'b1;
    wait_for(0, 10, "tmo_start", cyc);
    check("err_tmo_before", 32'(err_tmo), 32'h0);
    wait_for(1, TMO + 10, "tmo_ack", cyc);
    check("tmo_cycles", 32'(cyc >= TMO && cyc <= TMO + 1), 32'h1);
    host_req = 1'b0;
    no_done = 1'b0;
    check("err_tmo_set", 32'(err_tmo), 32'h1);

    // Polling continues after the timeout
    exp_txn.push_back('{dir: 1'b0, areg: 5'h01, txd: 16'h0000});
    wait_for(0, P + 20, "poll_after_tmo", cyc);

    // Reset in the middle of that poll
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst1");
    repeat (10) @(posedge clk);
    #1;
    base = n_start;
    exp_txn.push_back('{dir: 1'b1, areg: 5'h00, txd: 16'h8000});
    exp_txn.push_back('{dir: 1'b1, areg: 5'h04, txd: 16'h01E1});
    rst = 1'b1;
    wait_for(0, W + 10, "reinit_start", cyc);
    check("reinit_wait_window", 32'(cyc >= W + 1 && cyc <= W + 3), 32'h1);
    wait_for(3, 40, "reinit_done", cyc);
    check("reinit_starts", 32'(n_start - base), 32'd2);
    check("reinit_err_tmo", 32'(err_tmo), 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check("txn_queue_empty", 32'(exp_txn.size()), 32'd0);
    check("host_queue_empty", 32'(exp_host.size()), 32'd0);
    check("link_queue_empty", 32'(exp_link.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
